// File: rtl/velocity_cell_reader.sv
// Read-side initiator for one per-cell velocity RAM: reads the particle count, then streams
// every {vz, vy, vx} word out through a 2-entry skid FIFO. Optional out_last: VEL_CELL_READER_LAST_EN.
module velocity_cell_reader #(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned PARTICLE_NUM = 220,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef VEL_CELL_READER_LAST_EN
    ,
    output logic                  out_last
`endif
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FINISH} state_t;

    state_t                state_q;
    logic                  busy_q, done_q, count_err_q, rden_q, rd_vld_q;
    logic [ADDR_WIDTH-1:0] count_q, addr_q, rd_ptr_q, rd_idx_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [ADDR_WIDTH-1:0] fifo_idx_q  [2];
    logic                  head_q, tail_q;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic                  fifo_empty, valid_c, accept, push, pop, credit_ok, drained;
    logic [ADDR_WIDTH-1:0] raw_count, clamped_count;

    // Returning RAM data bypasses the FIFO when it is empty, so a read reaches the consumer next cycle.
    always_comb begin
        fifo_empty    = (fifo_cnt_q == 2'd0);
        valid_c       = !fifo_empty || rd_vld_q;
        accept        = valid_c && out_ready;
        pop           = accept && !fifo_empty;
        push          = rd_vld_q && !(fifo_empty && accept);
        fifo_cnt_d    = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
        // Held entries plus reads still on their way may never exceed the two FIFO slots.
        credit_ok     = (fifo_cnt_d + {1'b0, rden_q}) < 2'd2;
        drained       = (fifo_cnt_d == 2'd0) && !rden_q;
        raw_count     = mem_q[ADDR_WIDTH-1:0];
        clamped_count = (raw_count > MAX_COUNT) ? MAX_COUNT : raw_count;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[tail_q] <= mem_q;
            fifo_idx_q[tail_q]  <= rd_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_err_q <= 1'b0;
            count_q     <= '0;
            addr_q      <= '0;
            rden_q      <= 1'b0;
            rd_ptr_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (push) tail_q <= ~tail_q;
            if (pop)  head_q <= ~head_q;
            fifo_cnt_q <= fifo_cnt_d;
            // The count word returns while in WAIT_CNT and is consumed by the FSM, not the FIFO.
            rd_vld_q   <= rden_q && (state_q != RD_CNT);
            if (rden_q) rd_idx_q <= addr_q;
            rden_q     <= 1'b0;
            done_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RD_CNT;
                        busy_q      <= 1'b1;
                        count_err_q <= 1'b0;
                        rden_q      <= 1'b1;
                        addr_q      <= '0;
                    end
                end
                RD_CNT: state_q <= WAIT_CNT;
                WAIT_CNT: begin
                    count_q     <= clamped_count;
                    count_err_q <= (raw_count > MAX_COUNT);
                    if (clamped_count == '0) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        rden_q   <= 1'b1;
                        addr_q   <= ADDR_WIDTH'(1);
                        rd_ptr_q <= ADDR_WIDTH'(2);
                        state_q  <= (clamped_count == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (credit_ok) begin
                        rden_q   <= 1'b1;
                        addr_q   <= rd_ptr_q;
                        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
                        if (rd_ptr_q == count_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign particle_count = count_q;
    assign count_err      = count_err_q;
    assign mem_address    = addr_q;
    assign mem_rden       = rden_q;
    assign mem_wren       = 1'b0;
    assign mem_data       = '0;
    assign out_valid      = valid_c;
    assign out_data       = fifo_empty ? mem_q : fifo_data_q[head_q];
    assign out_index      = fifo_empty ? rd_idx_q : fifo_idx_q[head_q];
`ifdef VEL_CELL_READER_LAST_EN
    assign out_last       = valid_c && (out_index == count_q);
`endif

endmodule

// File: tb/tb_velocity_cell_reader.sv
// Bench for velocity_cell_reader: vector table, hand sequences and randomized cells checked
// against a queue of expected {data, index} beats built from the memory image.
module tb_velocity_cell_reader;
    localparam int unsigned DW = 96;
    localparam int unsigned PN = 220;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic          busy, done, count_err, mem_rden, mem_wren, out_valid;
    logic [AW-1:0] particle_count, mem_address, out_index;
    logic [DW-1:0] mem_data, out_data;
    logic [DW-1:0] mem_q = '0;
`ifdef VEL_CELL_READER_LAST_EN
    logic          out_last;
`endif

    velocity_cell_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .particle_count(particle_count), .count_err(count_err),
        .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_data(mem_data), .mem_q(mem_q), .out_data(out_data), .out_index(out_index),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef VEL_CELL_READER_LAST_EN
        , .out_last(out_last)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:255];
    always @(posedge clk) if (mem_rden) mem_q <= mem[mem_address];

    typedef struct {
        int raw;
        int mode;
        int exp_count;
        bit exp_err;
    } vec_t;

    int checks = 0, failures = 0, cyc = 0, rcyc = 0, ready_mode = 0;
    bit mon_en = 1'b0;
    logic [DW+AW-1:0] exp_q[$];
    logic [DW+AW-1:0] e;
    int exp_n, done_cnt, busy_cnt, first_valid_cyc, last_acc_cyc, done_cyc;
    int part_issued, accepted, cnt_reads, start_cyc;
    bit stall_prev;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 256; k++) mem[k] = {$urandom(), $urandom(), $urandom()};
    endtask

    // Consumer ready patterns: 0 always, 1 = 1,0,0 repeating, 2 coin flip, 3 mostly ready.
    initial forever begin
        @(posedge clk);
        #1;
        rcyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rcyc % 3 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_rden) begin
                if (mem_address == '0) cnt_reads++;
                else begin
                    part_issued++;
                    chk("rd_addr", mem_address, part_issued);
                    checks++;
                    if (part_issued - accepted > 2) begin
                        failures++;
                        $display("FAIL credit: outstanding %0d required <=2", part_issued - accepted);
                    end
                end
            end
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_idx", out_index, prev_idx);
            end
`ifdef VEL_CELL_READER_LAST_EN
            chk("out_last", out_last, out_valid && (out_index == AW'(exp_n)));
`endif
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat: got index %0d required none", out_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e[DW+AW-1:AW]);
                    chk("beat_idx", out_index, e[AW-1:0]);
                end
                accepted++;
                last_acc_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_index;
        end
    end

    task automatic run_cell(input int raw, input int mode, input bit extra_start,
                            input int exp_count, input bit exp_err);
        int n;
        int budget;
        n = (raw > int'(PN) - 1) ? int'(PN) - 1 : raw;
        mem[0] = {$urandom(), $urandom(), $urandom()};
        mem[0][AW-1:0] = AW'(raw);
        exp_q.delete();
        for (int k = 1; k <= n; k++) exp_q.push_back({mem[k], AW'(k)});
        exp_n = n;
        done_cnt = 0; busy_cnt = 0; first_valid_cyc = -1; last_acc_cyc = 0; done_cyc = 0;
        part_issued = 0; accepted = 0; cnt_reads = 0; stall_prev = 1'b0;
        ready_mode = mode;
        mon_en = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (extra_start) start = (cyc == start_cyc + 5);
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done required done within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
        chk("particle_count", particle_count, exp_count);
        chk("count_err", count_err, exp_err);
        chk("beats_left", exp_q.size(), 0);
        chk("beats_accepted", accepted, n);
        chk("done_pulses", done_cnt, 1);
        chk("count_reads", cnt_reads, 1);
        chk("particle_reads", part_issued, n);
        chk("busy_after", busy, 0);
        chk("mem_wren", mem_wren, 0);
        chk("mem_data", mem_data, 0);
        if (mode == 0) begin
            if (n == 0) begin
                chk("busy_cycles_empty", busy_cnt, 3);
                chk("no_valid_empty", first_valid_cyc < 0, 1);
            end else begin
                chk("first_valid_lat", first_valid_cyc - start_cyc, 4);
                chk("burst_span", last_acc_cyc - first_valid_cyc, n - 1);
                chk("done_lat", done_cyc - last_acc_cyc, 1);
                chk("busy_cycles", busy_cnt, n + 4);
            end
        end
        mon_en = 1'b0;
    endtask

    initial begin
        vec_t vt[9];
        int budget;
        int dn;
        int raw;
        int n;
        logic [31:0] w;

        vt[0] = '{raw: 5,   mode: 0, exp_count: 5,   exp_err: 1'b0};
        vt[1] = '{raw: 0,   mode: 0, exp_count: 0,   exp_err: 1'b0};
        vt[2] = '{raw: 8,   mode: 1, exp_count: 8,   exp_err: 1'b0};
        vt[3] = '{raw: 250, mode: 0, exp_count: 219, exp_err: 1'b1};
        vt[4] = '{raw: 1,   mode: 0, exp_count: 1,   exp_err: 1'b0};
        vt[5] = '{raw: 2,   mode: 3, exp_count: 2,   exp_err: 1'b0};
        vt[6] = '{raw: 219, mode: 2, exp_count: 219, exp_err: 1'b0};
        vt[7] = '{raw: 220, mode: 1, exp_count: 219, exp_err: 1'b1};
        vt[8] = '{raw: 7,   mode: 2, exp_count: 7,   exp_err: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rden", mem_rden, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_count", particle_count, 0);
        chk("rst_err", count_err, 0);
        rst = 1'b0;

        for (int k = 1; k < 256; k++) begin
            w = 32'(k) * 32'h3F80_0000;
            mem[k] = {w, w, w};
        end
        for (int i = 0; i < 9; i++) begin
            if (i == 1) fill_random();
            run_cell(vt[i].raw, vt[i].mode, 1'b0, vt[i].exp_count, vt[i].exp_err);
        end

        // A start pulse mid-transfer must be ignored.
        fill_random();
        run_cell(3, 0, 1'b1, 3, 1'b0);

        // Reset during beat 3 aborts silently; the next transfer is clean.
        fill_random();
        mem[0] = '0;
        mem[0][AW-1:0] = AW'(10);
        ready_mode = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        budget = 0;
        while (!(out_valid && out_index == AW'(3)) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("reach_beat3", out_index, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_rden", mem_rden, 0);
        chk("abort_addr", mem_address, 0);
        chk("abort_done", done, 0);
        chk("abort_count", particle_count, 0);
        rst = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("abort_quiet", dn, 0);
        run_cell(10, 0, 1'b0, 10, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            raw = int'($urandom_range(0, 255));
            n = (raw > int'(PN) - 1) ? int'(PN) - 1 : raw;
            run_cell(raw, int'($urandom_range(1, 3)), 1'b0, n, raw > int'(PN) - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
